// File: rtl/addx_accel_unit.sv
// ADDX accelerator functional unit: one op in flight, fixed-latency tagged result,
// private accumulator for ACC/ACCCLR.
module addx_accel_unit #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned LATENCY       = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     addx_valid_i,
    output logic                     addx_ready_o,
    input  logic [1:0]               op_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     addx_valid_o,
    output logic [XLEN-1:0]          addx_result_o,
    output logic [TRANS_ID_BITS-1:0] addx_trans_id_o
);

    // state | meaning
    // IDLE  | ready for a new op, no result pending
    // BUSY  | op latched, cnt counts down; result emitted when cnt==0
    typedef enum logic {IDLE, BUSY} state_e;

    localparam int unsigned CNT_W = 2;
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_ADDS   = 2'b01;
    localparam logic [1:0] OP_ACC    = 2'b10;
    localparam logic [1:0] OP_ACCCLR = 2'b11;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               op_q, op_d;
    logic [XLEN-1:0]          a_q, a_d;
    logic [XLEN-1:0]          b_q, b_d;
    logic [TRANS_ID_BITS-1:0] tag_q, tag_d;
    logic [XLEN-1:0]          acc_q, acc_d;

    logic                     fire;
    logic [XLEN-1:0]          res;
    logic [XLEN-1:0]          add_sum;
    logic [XLEN-1:0]          acc_sum;
    logic [XLEN:0]            adds_ext;

    // Saturating add works on a sign-extended XLEN+1 sum; the top two bits disagree on overflow.
    always_comb begin
        add_sum  = a_q + b_q;
        acc_sum  = acc_q + a_q;
        adds_ext = {a_q[XLEN-1], a_q} + {b_q[XLEN-1], b_q};
        res      = add_sum;
        unique case (op_q)
            OP_ADD: res = add_sum;
            OP_ADDS: begin
                if (adds_ext[XLEN:XLEN-1] == 2'b01)
                    res = {1'b0, {(XLEN-1){1'b1}}};
                else if (adds_ext[XLEN:XLEN-1] == 2'b10)
                    res = {1'b1, {(XLEN-1){1'b0}}};
                else
                    res = adds_ext[XLEN-1:0];
            end
            OP_ACC:    res = acc_sum;
            OP_ACCCLR: res = acc_q;
            default:   res = add_sum;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        acc_d   = acc_q;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (addx_valid_i) begin
                    op_d    = op_i;
                    a_d     = operand_a_i;
                    b_d     = operand_b_i;
                    tag_d   = trans_id_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    fire    = 1'b1;
                    state_d = IDLE;
                    if (op_q == OP_ACC)
                        acc_d = acc_sum;
                    else if (op_q == OP_ACCCLR)
                        acc_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything: no accept, no result, accumulator untouched.
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            fire    = 1'b0;
            acc_d   = acc_q;
            op_d    = op_q;
            a_d     = a_q;
            b_d     = b_q;
            tag_d   = tag_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
        end
    end

    assign addx_ready_o    = (state_q == IDLE);
    assign addx_valid_o    = fire;
    assign addx_result_o   = fire ? res : '0;
    assign addx_trans_id_o = fire ? tag_q : '0;

endmodule

// File: tb/tb_addx_accel_unit.sv
// Directed bench for addx_accel_unit: vector table plus flush, back-to-back and reset sequences.
module tb_addx_accel_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        addx_valid_i = 1'b0;
    logic        addx_ready_o;
    logic [1:0]  op_i = '0;
    logic [63:0] operand_a_i = '0;
    logic [63:0] operand_b_i = '0;
    logic [2:0]  trans_id_i = '0;
    logic        addx_valid_o;
    logic [63:0] addx_result_o;
    logic [2:0]  addx_trans_id_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  tag;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    addx_accel_unit #(.XLEN(64), .TRANS_ID_BITS(3), .LATENCY(2)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .addx_valid_i    (addx_valid_i),
        .addx_ready_o    (addx_ready_o),
        .op_i            (op_i),
        .operand_a_i     (operand_a_i),
        .operand_b_i     (operand_b_i),
        .trans_id_i      (trans_id_i),
        .addx_valid_o    (addx_valid_o),
        .addx_result_o   (addx_result_o),
        .addx_trans_id_o (addx_trans_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one op right after an edge and checks every cycle up to the first idle cycle.
    task automatic do_op(input string name, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] tag, input logic [63:0] exp);
        @(posedge clk_i); #1;
        addx_valid_i = 1'b1;
        op_i = op; operand_a_i = a; operand_b_i = b; trans_id_i = tag;
        #1 check({name, ".ready_c0"}, 64'(addx_ready_o), 64'd1);
        @(posedge clk_i); #1;
        addx_valid_i = 1'b0;
        #1;
        check({name, ".ready_c1"}, 64'(addx_ready_o), 64'd0);
        check({name, ".valid_c1"}, 64'(addx_valid_o), 64'd0);
        @(posedge clk_i); #2;
        check({name, ".valid_c2"}, 64'(addx_valid_o), 64'd1);
        check({name, ".result"}, addx_result_o, exp);
        check({name, ".tag"}, 64'(addx_trans_id_o), 64'(tag));
        check({name, ".ready_c2"}, 64'(addx_ready_o), 64'd0);
        @(posedge clk_i); #2;
        check({name, ".valid_c3"}, 64'(addx_valid_o), 64'd0);
        check({name, ".ready_c3"}, 64'(addx_ready_o), 64'd1);
        check({name, ".result_c3"}, addx_result_o, 64'd0);
    endtask

    initial begin
        vecs[0] = '{"add_wrap",   2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd5, 64'd1};
        vecs[1] = '{"add_plain",  2'b00, 64'd3, 64'd4, 3'd1, 64'd7};
        vecs[2] = '{"adds_pos",   2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd2, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[3] = '{"adds_neg",   2'b01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 64'h8000_0000_0000_0000};
        vecs[4] = '{"adds_norm",  2'b01, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 3'd4, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5] = '{"acc_10",     2'b10, 64'd10, 64'd99, 3'd6, 64'd10};
        vecs[6] = '{"acc_m3",     2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 3'd7, 64'd7};
        vecs[7] = '{"accclr",     2'b11, 64'd55, 64'd66, 3'd0, 64'd7};
        vecs[8] = '{"acc_1",      2'b10, 64'd1, 64'd0, 3'd2, 64'd1};
        vecs[9] = '{"adds_sat_n", 2'b01, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 3'd5, 64'h8000_0000_0000_0000};

        #2;
        check("rst.ready", 64'(addx_ready_o), 64'd1);
        check("rst.valid", 64'(addx_valid_o), 64'd0);
        check("rst.result", addx_result_o, 64'd0);
        check("rst.tag", 64'(addx_trans_id_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);

        // Flush in the result cycle of ACC a=4 (acc==1), with a competing op on the inputs.
        @(posedge clk_i); #1;
        addx_valid_i = 1'b1; op_i = 2'b10; operand_a_i = 64'd4; trans_id_i = 3'd3;
        @(posedge clk_i); #1;
        addx_valid_i = 1'b0;
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        addx_valid_i = 1'b1; op_i = 2'b00; operand_a_i = 64'd8; operand_b_i = 64'd8; trans_id_i = 3'd6;
        #1 check("flush.valid", 64'(addx_valid_o), 64'd0);
        check("flush.result", addx_result_o, 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; addx_valid_i = 1'b0;
        #1 check("flush.ready_after", 64'(addx_ready_o), 64'd1);
        check("flush.valid_after", 64'(addx_valid_o), 64'd0);
        @(posedge clk_i); #2;
        check("flush.no_accept", 64'(addx_ready_o), 64'd1);
        check("flush.no_pulse", 64'(addx_valid_o), 64'd0);
        do_op("flush_accclr", 2'b11, 64'd0, 64'd0, 3'd4, 64'd1);

        // Valid held across BUSY with the tag changed: second op waits for the idle cycle.
        @(posedge clk_i); #1;
        addx_valid_i = 1'b1; op_i = 2'b00; operand_a_i = 64'd1; operand_b_i = 64'd1; trans_id_i = 3'd1;
        @(posedge clk_i); #1;
        operand_a_i = 64'd2; operand_b_i = 64'd2; trans_id_i = 3'd2;
        #1 check("hold.busy_ready", 64'(addx_ready_o), 64'd0);
        @(posedge clk_i); #2;
        check("hold.first_valid", 64'(addx_valid_o), 64'd1);
        check("hold.first_result", addx_result_o, 64'd2);
        check("hold.first_tag", 64'(addx_trans_id_o), 64'd1);
        @(posedge clk_i); #2;
        check("hold.idle_ready", 64'(addx_ready_o), 64'd1);
        check("hold.idle_valid", 64'(addx_valid_o), 64'd0);
        @(posedge clk_i); #1;
        addx_valid_i = 1'b0;
        #1 check("hold.second_busy", 64'(addx_ready_o), 64'd0);
        @(posedge clk_i); #2;
        check("hold.second_valid", 64'(addx_valid_o), 64'd1);
        check("hold.second_result", addx_result_o, 64'd4);
        check("hold.second_tag", 64'(addx_trans_id_o), 64'd2);
        @(posedge clk_i); #2;
        check("hold.done_valid", 64'(addx_valid_o), 64'd0);

        // Async reset in the result cycle of an ACC, after acc was made nonzero.
        do_op("pre_rst_acc", 2'b10, 64'd9, 64'd0, 3'd3, 64'd9);
        @(posedge clk_i); #1;
        addx_valid_i = 1'b1; op_i = 2'b10; operand_a_i = 64'd5; trans_id_i = 3'd7;
        @(posedge clk_i); #1;
        addx_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1 check("arst.valid", 64'(addx_valid_o), 64'd0);
        check("arst.ready", 64'(addx_ready_o), 64'd1);
        check("arst.result", addx_result_o, 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        do_op("arst_accclr", 2'b11, 64'd0, 64'd0, 3'd5, 64'd0);

        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
